cache_line_fill: RTL and testbench
==================================

# cache_line_fill

Line fill engine for the set-associative cache. On a miss it issues one line request to memory, then captures a 16-beat, 32-bit critical-word-first wrapping burst into a 16-word line register. The captured line drives the cache's 16-to-1 word-select mux directly, and its word offset is presented as that mux's select.

## Interface
- `WORD_W`, default 32, width of one data word and one address.
- `LINE_WORDS`, fixed at 16, words per line. The offset width is 4 bits and is not parameterisable.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `fill_req` in 1: miss request, sampled only in IDLE.
- `fill_addr` in 32: byte address of the missing word; bits [5:2] give the critical word offset.
- `fill_busy` out 1: high whenever the state is not IDLE.
- `mem_req` out 1: line request to memory, held until acknowledged.
- `mem_addr` out 32: line-aligned request address, `{fill_addr[31:6], 6'b0}`, registered.
- `mem_ack` in 1: memory accepts the request.
- `mem_valid` in 1: one data beat is present on `mem_data`.
- `mem_data` in 32: burst data word.
- `line_data` out 512: word i is at bits [32i+31:32i]; feeds mux inputs 0..15.
- `word_sel` out 4: latched critical offset; feeds the mux select.
- `crit_valid` out 1: one-cycle pulse when the critical word has been captured (early restart).
- `line_valid` out 1: one-cycle pulse when all 16 words have been captured.

## Operation
- **States:** IDLE, REQ, FILL, DONE.
- **IDLE → REQ:** on `fill_req` = 1.
  - Latch `word_sel` ← `fill_addr[5:2]`.
  - Latch `mem_addr`.
  - Clear `beat_cnt` to 0.
- **REQ:**
  - `mem_req` = 1.
  - On `mem_ack` = 1, go to FILL.
  - `mem_valid` is ignored in REQ, including the cycle of `mem_ack`.
- **FILL:** each cycle with `mem_valid` = 1:
  - Write `mem_data` into word `(word_sel + beat_cnt) mod 16`. The 4-bit add wraps naturally.
  - Increment `beat_cnt`.
  - On the beat with `beat_cnt` = 0, `crit_valid` pulses on the next cycle.
  - On the beat with `beat_cnt` = 15, go to DONE.
  - Gaps with `mem_valid` = 0 are allowed and hold all state.
- **DONE:** `line_valid` = 1 for exactly one cycle, then go to IDLE.
- `fill_req` is ignored in REQ, FILL and DONE. It is not queued.
- `mem_ack` and `mem_valid` are ignored in IDLE and DONE.
- `line_data` and `word_sel` hold their values after DONE until a new fill overwrites them.
  - Words not yet rewritten by an in-progress fill keep their old values.
  - The cache consumes `line_data` only on or after `line_valid`.
- **`beat_cnt`:** 4 bits. Beat 15 with `beat_cnt` = 15 is terminal, so no overflow is visible.
- **Reset:**
  - Asynchronous, at any point including mid-burst.
  - Forces state to IDLE.
  - Clears `beat_cnt`, `word_sel`, `mem_addr` and `line_data` to 0.
  - Drives `mem_req`, `fill_busy`, `crit_valid` and `line_valid` to 0.
  - Any burst still in flight after reset is discarded, because `mem_valid` is ignored in IDLE.

## Timing
- All outputs are registered or decoded from the state register only. There are no combinational input-to-output paths.
- **Request cycle:** `fill_req` high at edge E0 (IDLE).
  - `mem_req`, `fill_busy`, `mem_addr` and `word_sel` are valid after E0.
- **Acknowledge:** `mem_ack` sampled high at edge Ea.
  - `mem_req` is 0 after Ea.
  - The first beat can be accepted at edge Ea+1.
- **Critical word:** first beat at edge Eb.
  - The critical word is in `line_data` after Eb.
  - `crit_valid` is high for the cycle after Eb.
- **Line complete:** 16th beat at edge Ef.
  - `line_valid` is high for the cycle after Ef.
  - `fill_busy` drops after Ef+1.
- **Back-to-back fills:** a new `fill_req` is accepted at the earliest in the cycle after `line_valid`.
- **Minimum fill latency:** with `mem_ack` on the first REQ cycle and no beat gaps, `line_valid` is high at 18 cycles after the `fill_req` edge.

## Test plan
- **Reset values:** assert `rst_n` = 0 asynchronously mid-cycle.
  - Required: all outputs 0 immediately, including `line_data` = 0, without waiting for a clock edge.
- **Aligned fill:** `fill_addr` = 0x0000_1000, ack on the first REQ cycle, beats 0xA0..0xAF with no gaps.
  - Required: `mem_addr` = 0x0000_1000 and `word_sel` = 0.
  - Required: word i = 0xA0+i.
  - Required: `crit_valid` 1 cycle after the first beat; `line_valid` 18 cycles after `fill_req`.
- **Critical-word wrap:** `fill_addr` = 0x0000_2034 (offset 13), beats D0..D15 = 0x100..0x10F.
  - Required: word 13 = 0x100, word 15 = 0x102, word 0 = 0x103, word 12 = 0x10F.
  - Required: `word_sel` = 13 and `mem_addr` = 0x0000_2000.
- **Stalls and noise:**
  - Stimulus: `mem_ack` delayed 5 cycles; `mem_valid` pulsed during REQ and alongside `mem_ack`; 3 gap cycles inserted mid-burst.
  - Stimulus: a second `fill_req` (0xFFFF_FFC0) issued during FILL.
  - Required: REQ-phase beats are not captured and exactly 16 beats are written.
  - Required: `word_sel` and `mem_addr` are unchanged by the second request, and there is no second REQ after DONE.
- **Reset mid-burst:** `rst_n` low after 7 beats; then a new fill with offset 2 and 16 beats.
  - Required: state is IDLE and `line_data` is 0 after reset.
  - Required: the new fill completes normally with correct words.
- **Back-to-back fills:** a second fill requested the cycle after `line_valid`.
  - Required: `mem_req` reasserts 1 cycle later.
  - Required: words not yet overwritten keep the previous line's values until rewritten.

Source files
------------

// File: rtl/cache_line_fill.sv
`default_nettype none
// ============================================================================
//  Module   : cache_line_fill
//  Purpose  : Cache line fill engine. On a miss, issues one line request to
//             memory, then captures a 16-beat critical-word-first wrapping
//             burst into a 16-word line register that feeds the cache's
//             16-to-1 word-select mux.
//  Ports    : clk, rst_n          - clock, async active-low reset
//             fill_req/fill_addr  - miss request and missing byte address
//             fill_busy           - engine not idle
//             mem_req/mem_addr    - line request (held until mem_ack)
//             mem_ack             - memory accepted the request
//             mem_valid/mem_data  - burst data beat
//             line_data           - captured line, word i at [32i+31:32i]
//             word_sel            - latched critical word offset
//             crit_valid          - pulse: critical word captured
//             line_valid          - pulse: whole line captured
//  Revision : 1.0 - initial release
// ============================================================================
module cache_line_fill #(
    parameter int WORD_W = 32,
    localparam int LINE_WORDS = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         fill_req,
    input  logic [WORD_W-1:0]            fill_addr,
    output logic                         fill_busy,
    output logic                         mem_req,
    output logic [WORD_W-1:0]            mem_addr,
    input  logic                         mem_ack,
    input  logic                         mem_valid,
    input  logic [WORD_W-1:0]            mem_data,
    output logic [LINE_WORDS*WORD_W-1:0] line_data,
    output logic [3:0]                   word_sel,
    output logic                         crit_valid,
    output logic                         line_valid
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_FILL = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [3:0]        r_beat_cnt;
    logic [3:0]        r_word_sel;
    logic [3:0]        w_wr_idx;
    logic [WORD_W-1:0] r_mem_addr;
    logic [WORD_W-1:0] r_line [LINE_WORDS];
    logic              r_crit_valid;
    logic              w_beat;
    logic              w_unused_addr;

    // Byte-within-word bits play no part in a line fill.
    assign w_unused_addr = ^fill_addr[1:0];

    // A beat is only accepted in FILL; beats in REQ/IDLE/DONE are dropped.
    assign w_beat   = (r_state == c_FILL) && mem_valid;
    // Critical-word-first wrap: 4-bit add rolls over naturally.
    assign w_wr_idx = r_word_sel + r_beat_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: if (fill_req) w_state_nxt = c_REQ;
            c_REQ:  if (mem_ack)  w_state_nxt = c_FILL;
            c_FILL: if (w_beat && (r_beat_cnt == 4'd15)) w_state_nxt = c_DONE;
            c_DONE: w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt   <= 4'd0;
            r_word_sel   <= 4'd0;
            r_mem_addr   <= '0;
            r_crit_valid <= 1'b0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                r_line[i] <= '0;
            end
        end else begin
            // First beat of the burst is always the critical word.
            r_crit_valid <= w_beat && (r_beat_cnt == 4'd0);
            if ((r_state == c_IDLE) && fill_req) begin
                r_word_sel <= fill_addr[5:2];
                r_mem_addr <= {fill_addr[WORD_W-1:6], 6'b0};
                r_beat_cnt <= 4'd0;
            end
            if (w_beat) begin
                r_line[w_wr_idx] <= mem_data;
                r_beat_cnt       <= r_beat_cnt + 4'd1;
            end
        end
    end

    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_line
        assign line_data[gi*WORD_W +: WORD_W] = r_line[gi];
    end

    assign fill_busy  = (r_state != c_IDLE);
    assign mem_req    = (r_state == c_REQ);
    assign line_valid = (r_state == c_DONE);
    assign crit_valid = r_crit_valid;
    assign word_sel   = r_word_sel;
    assign mem_addr   = r_mem_addr;

endmodule
`default_nettype wire

// File: tb/tb_cache_line_fill.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_line_fill
//  Purpose  : Self-checking bench for cache_line_fill using a table of fill
//             vectors plus hand sequences for reset mid-burst.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cache_line_fill;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         fill_req;
    logic [31:0]  fill_addr;
    logic         fill_busy;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack;
    logic         mem_valid;
    logic [31:0]  mem_data;
    logic [511:0] line_data;
    logic [3:0]   word_sel;
    logic         crit_valid;
    logic         line_valid;

    always #5 clk = ~clk;

    cache_line_fill #(.WORD_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fill_req   (fill_req),
        .fill_addr  (fill_addr),
        .fill_busy  (fill_busy),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_valid  (mem_valid),
        .mem_data   (mem_data),
        .line_data  (line_data),
        .word_sel   (word_sel),
        .crit_valid (crit_valid),
        .line_valid (line_valid)
    );

    typedef struct {
        logic [31:0] addr;
        int          ackDelay;
        int          gapAt;
        int          gapLen;
        bit          noise;
        logic [31:0] base;
        logic [3:0]  expSel;
        logic [31:0] expMemAddr;
        int          expLatency;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc;
    int          lvCyc;
    int          critCyc;
    logic [31:0] model [16];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] model_line();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = model[i];
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (line_valid && lvCyc < 0) lvCyc = cyc;
        if (crit_valid && critCyc < 0) critCyc = cyc;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},  fill_busy,  0);
        chk({tag, "_mreq"},  mem_req,    0);
        chk({tag, "_maddr"}, mem_addr,   0);
        chk({tag, "_sel"},   word_sel,   0);
        chk({tag, "_line"},  line_data,  0);
        chk({tag, "_crit"},  crit_valid, 0);
        chk({tag, "_lv"},    line_valid, 0);
    endtask

    // Run one fill; abortAfter < 16 asserts reset mid-cycle after that many beats.
    task automatic run_fill(input vec_t v, input int abortAfter);
        int expCrit;
        expCrit = -1;
        cyc = 0; lvCyc = -1; critCyc = -1;
        fill_addr = v.addr;
        fill_req  = 1'b1;
        step();
        fill_req  = 1'b0;
        chk("req_mem_req", mem_req, 1);
        chk("req_busy", fill_busy, 1);
        chk("req_mem_addr", mem_addr, v.expMemAddr);
        chk("req_word_sel", word_sel, v.expSel);
        for (int d = 0; d < v.ackDelay; d++) begin
            mem_valid = v.noise;
            mem_data  = 32'hDEAD_0000 + d;
            step();
        end
        mem_ack   = 1'b1;
        mem_valid = v.noise;
        mem_data  = 32'hDEAD_FFFF;
        step();
        mem_ack   = 1'b0;
        mem_valid = 1'b0;
        chk("ack_mem_req_drop", mem_req, 0);
        chk("req_beats_ignored", line_data, model_line());
        for (int n = 0; n < 16; n++) begin
            if (n == abortAfter) begin
                #2;
                rst_n = 1'b0;
                #1;
                check_all_zero("async_rst");
                mem_valid = 1'b1;
                mem_data  = 32'hBAD0_0000;
                step();
                step();
                rst_n = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    mem_data = 32'hBAD0_0001 + k;
                    step();
                end
                mem_valid = 1'b0;
                chk("post_rst_busy", fill_busy, 0);
                chk("post_rst_mreq", mem_req, 0);
                chk("post_rst_line", line_data, 0);
                for (int i = 0; i < 16; i++) model[i] = 32'h0;
                return;
            end
            if (n == v.gapAt) begin
                for (int g = 0; g < v.gapLen; g++) step();
            end
            mem_valid = 1'b1;
            mem_data  = v.base + n;
            if (v.noise && n == 4) begin
                fill_req  = 1'b1;
                fill_addr = 32'hFFFF_FFC0;
            end
            step();
            mem_valid = 1'b0;
            fill_req  = 1'b0;
            model[(int'(v.expSel) + n) % 16] = v.base + n;
            if (n == 0) expCrit = cyc;
            chk("beat_line", line_data, model_line());
            if (n == 14) chk("lv_early", line_valid, 0);
        end
        chk("done_lv", line_valid, 1);
        chk("done_busy", fill_busy, 1);
        chk("latency", lvCyc, v.expLatency);
        chk("crit_cycle", critCyc, expCrit);
        chk("done_word_sel", word_sel, v.expSel);
        chk("done_mem_addr", mem_addr, v.expMemAddr);
        step();
        chk("idle_lv", line_valid, 0);
        chk("idle_busy", fill_busy, 0);
        chk("idle_no_req", mem_req, 0);
        chk("idle_crit", crit_valid, 0);
    endtask

    vec_t vecs [4];
    vec_t vAbort;
    vec_t vAfter;

    initial begin
        vecs[0] = '{32'h0000_1000, 0, 16, 0, 1'b0, 32'h0000_00A0, 4'd0,  32'h0000_1000, 18};
        vecs[1] = '{32'h0000_2034, 0, 16, 0, 1'b0, 32'h0000_0100, 4'd13, 32'h0000_2000, 18};
        vecs[2] = '{32'h0000_3A5C, 5, 8,  3, 1'b1, 32'h0000_5550, 4'd7,  32'h0000_3A40, 26};
        vecs[3] = '{32'hFFFF_FFC4, 0, 16, 0, 1'b0, 32'hBEEF_0000, 4'd1,  32'hFFFF_FFC0, 18};
        vAbort  = '{32'h0000_5010, 0, 16, 0, 1'b0, 32'h0000_0900, 4'd4,  32'h0000_5000, 18};
        vAfter  = '{32'h0000_4008, 0, 16, 0, 1'b0, 32'h0000_0700, 4'd2,  32'h0000_4000, 18};
        for (int i = 0; i < 16; i++) model[i] = 32'h0;

        rst_n     = 1'b0;
        fill_req  = 1'b0;
        fill_addr = 32'h0;
        mem_ack   = 1'b0;
        mem_valid = 1'b0;
        mem_data  = 32'h0;
        cyc = 0; lvCyc = -1; critCyc = -1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 4; i++) begin
            run_fill(vecs[i], 16);
            if (i == 1) begin
                chk("wrap_w13", line_data[13*32 +: 32], 32'h100);
                chk("wrap_w15", line_data[15*32 +: 32], 32'h102);
                chk("wrap_w0",  line_data[0*32  +: 32], 32'h103);
                chk("wrap_w12", line_data[12*32 +: 32], 32'h10F);
            end
        end

        run_fill(vAbort, 7);
        run_fill(vAfter, 16);
        chk("after_rst_w2", line_data[2*32 +: 32], 32'h700);
        chk("after_rst_w1", line_data[1*32 +: 32], 32'h70F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
